write_back_stage: RTL

Final pipeline stage of the MIPS16 core, directly upstream of `register_file`. It registers each retiring instruction from the memory stage, waits for late load data where needed, and drives the register file write port (`reg_write_en`, `reg_write_dest`, `reg_write_data`). It also applies backpressure to the memory stage while a load is outstanding, discards flushed work, and keeps a retire counter and a load-timeout flag for debug.

---
 rtl/write_back_pkg.sv | 20 ++
 rtl/load_wait_timer.sv | 31 +++
 rtl/write_back_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/write_back_pkg.sv
// Shared types and widths for the write-back stage of the MIPS16 core.
package write_back_pkg;

  // Datapath widths used by the MIPS16 core.
  localparam int DATA_W   = 16;
  localparam int REG_W    = 3;

  // Width of the retire counter; it wraps naturally at this width.
  localparam int RETIRE_W = 16;

  // Width of the load wait timer; wide enough for the largest timeout (255).
  localparam int TIMER_W  = 8;

  // Write-back FSM states.
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_wait_timer.sv
// Up-counter with clear and enable. 'expired' flags the enabled cycle whose
// increment would bring the count to LIMIT, so the owner can leave on that edge.
module load_wait_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;

  // Counter: clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign expired = en && !clear && (count_q == LAST);

endmodule

// File: rtl/write_back_stage.sv
// Final MIPS16 pipeline stage: registers retiring instructions, waits for
// late load data, and drives the register file write port.
//
// Handshake: an instruction transfers on a rising edge where i_valid && o_ready.
// o_ready is combinational (IDLE and no flush); i_valid may be held or dropped
// freely, nothing is buffered beyond the accepted instruction.
//
// A retiring result sits in a one-deep "pending" register for one cycle; that is
// the cycle in which o_reg_write_en is visible. The retire counter advances at
// the end of that cycle, so a flush during it cancels both the write and the count.
module write_back_stage
  import write_back_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_write_en,
  input  logic [REG_W-1:0]  i_write_dest,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_is_load,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rdata_valid,
  input  logic              i_flush,
  output logic              o_reg_write_en,
  output logic [REG_W-1:0]  o_reg_write_dest,
  output logic [DATA_W-1:0] o_reg_write_data,
  output logic [RETIRE_W-1:0] o_retire_count,
  output logic              o_load_timeout
);

  wb_state_e state_q, state_d;

  // FSM control strobes.
  logic accept;
  logic load_accept;
  logic nonload_accept;
  logic timer_en;
  logic timer_expired;
  logic load_done;
  logic commit;
  logic show_write;

  // Load bookkeeping captured at acceptance.
  logic              load_we_q;
  logic [REG_W-1:0]  load_dest_q;

  // Pending result, visible on the write port for exactly one cycle.
  logic              pend_q;
  logic              pend_we_q;
  logic [REG_W-1:0]  pend_dest_q;
  logic [DATA_W-1:0] pend_data_q;

  // Last committed destination/data, held while no write is shown.
  logic [REG_W-1:0]  held_dest_q;
  logic [DATA_W-1:0] held_data_q;

  logic [RETIRE_W-1:0] retire_q;
  logic                timeout_q;

  load_wait_timer #(
    .WIDTH (TIMER_W),
    .LIMIT (LOAD_TIMEOUT)
  ) u_load_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (load_accept),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush overrides everything; data on the timeout edge wins.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (load_accept) state_d = WAIT_LOAD;
        WAIT_LOAD: if (i_mem_rdata_valid || timer_expired) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs and control strobes.
  always_comb begin
    o_ready        = (state_q == IDLE) && !i_flush;
    accept         = i_valid && o_ready;
    load_accept    = accept && i_is_load;
    nonload_accept = accept && !i_is_load;
    timer_en       = (state_q == WAIT_LOAD) && !i_mem_rdata_valid && !i_flush;
    load_done      = (state_q == WAIT_LOAD) && i_mem_rdata_valid && !i_flush;
    commit         = pend_q && !i_flush;
    show_write     = commit && pend_we_q;
  end

  // Datapath: pending result, held port values, retire counter, timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_we_q   <= 1'b0;
      load_dest_q <= '0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_dest_q <= '0;
      pend_data_q <= '0;
      held_dest_q <= '0;
      held_data_q <= '0;
      retire_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (show_write) begin
        held_dest_q <= pend_dest_q;
        held_data_q <= pend_data_q;
      end
      if (commit) begin
        retire_q <= retire_q + RETIRE_W'(1);
      end

      if (nonload_accept) begin
        pend_q      <= 1'b1;
        pend_we_q   <= i_write_en;
        pend_dest_q <= i_write_dest;
        pend_data_q <= i_alu_result;
      end else if (load_done) begin
        pend_q      <= 1'b1;
        pend_we_q   <= load_we_q;
        pend_dest_q <= load_dest_q;
        pend_data_q <= i_mem_rdata;
      end else begin
        pend_q      <= 1'b0;
      end

      if (load_accept) begin
        load_we_q   <= i_write_en;
        load_dest_q <= i_write_dest;
      end

      if (timer_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_reg_write_en   = show_write;
  assign o_reg_write_dest = show_write ? pend_dest_q : held_dest_q;
  assign o_reg_write_data = show_write ? pend_data_q : held_data_q;
  assign o_retire_count   = retire_q;
  assign o_load_timeout   = timeout_q;

endmodule
